// File: rtl/core_pkg.sv
// Shared definitions for the RV32 pipeline: datapath widths, ALU NOP code and
// the ID/EX hazard FSM states.
package core_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned ALU_OP_WIDTH = 4;
  localparam int unsigned REG_IDX_W    = 5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_NOP = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_e;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard term: a load in EX whose rd is read by the
// instruction currently in ID.
module load_use_detector (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       haz
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_uses_rs1 & (ex_rd == id_rs1);
    rs2_hit = id_uses_rs2 & (ex_rd == id_rs2);
    haz     = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble injection, branch flush and stall hold.
// Optional macro BUBBLE_COUNTER_EN adds a 32-bit count of injected load-use bubbles.
module id_ex_stage #(
  parameter int unsigned XLEN             = core_pkg::XLEN,
  parameter int unsigned ALU_OP_WIDTH     = core_pkg::ALU_OP_WIDTH,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_in,
  input  logic                    flush_in,
  input  logic                    id_valid,
  input  logic [XLEN-1:0]         id_pc,
  input  logic [XLEN-1:0]         id_rs1_data,
  input  logic [XLEN-1:0]         id_rs2_data,
  input  logic [XLEN-1:0]         id_imm,
  input  logic [4:0]              id_rs1,
  input  logic [4:0]              id_rs2,
  input  logic [4:0]              id_rd,
  input  logic                    id_uses_rs1,
  input  logic                    id_uses_rs2,
  input  logic                    id_immediate,
  input  logic                    id_pc_operation,
  input  logic                    id_mem_read,
  input  logic                    id_mem_write,
  input  logic                    id_reg_write,
  input  logic [ALU_OP_WIDTH-1:0] id_alu_op,
  output logic                    ex_valid,
  output logic [XLEN-1:0]         ex_pc,
  output logic [XLEN-1:0]         ex_rs1_data,
  output logic [XLEN-1:0]         ex_rs2_data,
  output logic [XLEN-1:0]         ex_imm,
  output logic [4:0]              ex_rs1,
  output logic [4:0]              ex_rs2,
  output logic [4:0]              ex_rd,
  output logic                    ex_immediate,
  output logic                    ex_pc_operation,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write,
  output logic                    ex_reg_write,
  output logic [ALU_OP_WIDTH-1:0] ex_alu_op,
  output logic                    hold_if_id,
  output logic                    load_use_bubble
`ifdef BUBBLE_COUNTER_EN
  ,
  output logic [31:0]             bubble_count
`endif
);

  import core_pkg::*;

  typedef struct packed {
    logic                    valid;
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic [XLEN-1:0]         imm;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [4:0]              rd;
    logic                    immediate;
    logic                    pc_operation;
    logic                    mem_read;
    logic                    mem_write;
    logic                    reg_write;
    logic [ALU_OP_WIDTH-1:0] alu_op;
  } ex_pl_t;

  localparam logic [1:0] EXTRA_BUBBLES = 2'(LOAD_USE_BUBBLES - 1);

  ex_pl_t     ex_q;
  ex_pl_t     id_pl;
  state_e     state;
  logic [1:0] remaining;
  logic       haz;
  logic       bubble_cycle;

  load_use_detector u_detector (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_rd       (ex_q.rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .haz         (haz)
  );

  // Invalid ID slots carry their fields through but never any side-effecting control.
  always_comb begin
    id_pl              = '0;
    id_pl.valid        = id_valid;
    id_pl.pc           = id_pc;
    id_pl.rs1_data     = id_rs1_data;
    id_pl.rs2_data     = id_rs2_data;
    id_pl.imm          = id_imm;
    id_pl.rs1          = id_rs1;
    id_pl.rs2          = id_rs2;
    id_pl.rd           = id_rd;
    id_pl.alu_op       = ALU_OP_WIDTH'(ALU_OP_NOP);
    if (id_valid) begin
      id_pl.immediate    = id_immediate;
      id_pl.pc_operation = id_pc_operation;
      id_pl.mem_read     = id_mem_read;
      id_pl.mem_write    = id_mem_write;
      id_pl.reg_write    = id_reg_write;
      id_pl.alu_op       = id_alu_op;
    end
  end

  // In BUBBLE the hazard term is moot: EX already holds a bubble.
  assign bubble_cycle    = (state == ST_BUBBLE) | haz;
  assign load_use_bubble = ~rst & ~flush_in & ~stall_in & bubble_cycle;
  assign hold_if_id      = ~rst & ~flush_in & (stall_in | bubble_cycle);

  always_ff @(posedge clk) begin
    if (rst || flush_in) begin
      ex_q      <= '0;
      state     <= ST_RUN;
      remaining <= 2'd0;
    end else if (stall_in) begin
      ex_q      <= ex_q;
    end else if (bubble_cycle) begin
      ex_q <= '0;
      if (state == ST_RUN) begin
        if (LOAD_USE_BUBBLES > 1) begin
          remaining <= EXTRA_BUBBLES;
          state     <= ST_BUBBLE;
        end
      end else begin
        remaining <= remaining - 2'd1;
        if (remaining == 2'd1) state <= ST_RUN;
      end
    end else begin
      ex_q <= id_pl;
    end
  end

`ifdef BUBBLE_COUNTER_EN
  always_ff @(posedge clk) begin
    if (rst) bubble_count <= 32'd0;
    else if (load_use_bubble) bubble_count <= bubble_count + 32'd1;
  end
`endif

  assign ex_valid        = ex_q.valid;
  assign ex_pc           = ex_q.pc;
  assign ex_rs1_data     = ex_q.rs1_data;
  assign ex_rs2_data     = ex_q.rs2_data;
  assign ex_imm          = ex_q.imm;
  assign ex_rs1          = ex_q.rs1;
  assign ex_rs2          = ex_q.rs2;
  assign ex_rd           = ex_q.rd;
  assign ex_immediate    = ex_q.immediate;
  assign ex_pc_operation = ex_q.pc_operation;
  assign ex_mem_read     = ex_q.mem_read;
  assign ex_mem_write    = ex_q.mem_write;
  assign ex_reg_write    = ex_q.reg_write;
  assign ex_alu_op       = ex_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: three instances (1, 2, 3 bubbles) share one ID stream;
// a directed table plus random traffic are checked against a remaining-bubbles model.
module tb_id_ex_stage;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_in, flush_in, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_immediate, id_pc_operation;
  logic        id_mem_read, id_mem_write, id_reg_write;
  logic [3:0]  id_alu_op;

  logic        o_valid [NI];
  logic [31:0] o_pc [NI], o_rs1_data [NI], o_rs2_data [NI], o_imm [NI];
  logic [4:0]  o_rs1 [NI], o_rs2 [NI], o_rd [NI];
  logic        o_immediate [NI], o_pc_operation [NI];
  logic        o_mem_read [NI], o_mem_write [NI], o_reg_write [NI];
  logic [3:0]  o_alu_op [NI];
  logic        o_hold [NI], o_lub [NI];
  logic [31:0] o_bc [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    id_ex_stage #(.XLEN(32), .ALU_OP_WIDTH(4), .LOAD_USE_BUBBLES(g + 1)) dut (
      .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
      .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
      .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_immediate(id_immediate), .id_pc_operation(id_pc_operation),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
      .ex_valid(o_valid[g]), .ex_pc(o_pc[g]), .ex_rs1_data(o_rs1_data[g]),
      .ex_rs2_data(o_rs2_data[g]), .ex_imm(o_imm[g]), .ex_rs1(o_rs1[g]),
      .ex_rs2(o_rs2[g]), .ex_rd(o_rd[g]), .ex_immediate(o_immediate[g]),
      .ex_pc_operation(o_pc_operation[g]), .ex_mem_read(o_mem_read[g]),
      .ex_mem_write(o_mem_write[g]), .ex_reg_write(o_reg_write[g]),
      .ex_alu_op(o_alu_op[g]), .hold_if_id(o_hold[g]), .load_use_bubble(o_lub[g])
`ifdef BUBBLE_COUNTER_EN
      , .bubble_count(o_bc[g])
`endif
    );
`ifndef BUBBLE_COUNTER_EN
    assign o_bc[g] = 32'd0;
`endif
  end

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        immediate, pc_operation, mem_read, mem_write, reg_write;
    logic [3:0]  alu_op;
  } ex_t;

  typedef struct {
    bit         rst, stall, flush, valid;
    logic [4:0] rd, rs1, rs2;
    bit         u1, u2, mr;
    logic [2:0] eh, ev;
    logic [4:0] r0, r1, r2;
  } vec_t;

  ex_t         m_ex [NI];
  int          m_rem [NI];
  logic [31:0] m_bc [NI];
  int          compared = 0;
  int          mismatched = 0;

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s dut%0d (bubbles=%0d) t=%0t got=%h exp=%h", name, inst, inst + 1,
               $time, got, exp);
    end
  endtask

  function automatic ex_t zero_ex();
    ex_t e;
    e = '{valid: 1'b0, pc: 32'd0, rs1_data: 32'd0, rs2_data: 32'd0, imm: 32'd0,
          rs1: 5'd0, rs2: 5'd0, rd: 5'd0, immediate: 1'b0, pc_operation: 1'b0,
          mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0, alu_op: 4'd0};
    return e;
  endfunction

  // A load in EX feeding a register the ID instruction actually reads.
  function automatic bit model_haz(input int i);
    return m_ex[i].valid && m_ex[i].mem_read && m_ex[i].rd != 5'd0 && id_valid &&
           ((id_uses_rs1 && m_ex[i].rd == id_rs1) || (id_uses_rs2 && m_ex[i].rd == id_rs2));
  endfunction

  task automatic pre_edge();
    bit busy, eh, el;
    ex_t e;
    #1;
    for (int i = 0; i < NI; i++) begin
      busy = (m_rem[i] > 0) || model_haz(i);
      eh   = !rst && !flush_in && (stall_in || busy);
      el   = !rst && !flush_in && !stall_in && busy;
      check("hold_if_id", i, 32'(o_hold[i]), 32'(eh));
      check("load_use_bubble", i, 32'(o_lub[i]), 32'(el));
      if (rst) begin
        m_ex[i] = zero_ex(); m_rem[i] = 0; m_bc[i] = 32'd0;
      end else if (flush_in) begin
        m_ex[i] = zero_ex(); m_rem[i] = 0;
      end else if (stall_in) begin
        // everything holds
      end else if (busy) begin
        m_ex[i] = zero_ex();
        m_rem[i] = (m_rem[i] > 0) ? m_rem[i] - 1 : i;
        m_bc[i]++;
      end else begin
        e = zero_ex();
        e.valid = id_valid; e.pc = id_pc; e.rs1_data = id_rs1_data;
        e.rs2_data = id_rs2_data; e.imm = id_imm;
        e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd;
        if (id_valid) begin
          e.immediate = id_immediate; e.pc_operation = id_pc_operation;
          e.mem_read = id_mem_read; e.mem_write = id_mem_write;
          e.reg_write = id_reg_write; e.alu_op = id_alu_op;
        end
        m_ex[i] = e;
      end
    end
  endtask

  task automatic post_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("ex_valid", i, 32'(o_valid[i]), 32'(m_ex[i].valid));
      check("ex_pc", i, o_pc[i], m_ex[i].pc);
      check("ex_rs1_data", i, o_rs1_data[i], m_ex[i].rs1_data);
      check("ex_rs2_data", i, o_rs2_data[i], m_ex[i].rs2_data);
      check("ex_imm", i, o_imm[i], m_ex[i].imm);
      check("ex_rs1", i, 32'(o_rs1[i]), 32'(m_ex[i].rs1));
      check("ex_rs2", i, 32'(o_rs2[i]), 32'(m_ex[i].rs2));
      check("ex_rd", i, 32'(o_rd[i]), 32'(m_ex[i].rd));
      check("ex_immediate", i, 32'(o_immediate[i]), 32'(m_ex[i].immediate));
      check("ex_pc_operation", i, 32'(o_pc_operation[i]), 32'(m_ex[i].pc_operation));
      check("ex_mem_read", i, 32'(o_mem_read[i]), 32'(m_ex[i].mem_read));
      check("ex_mem_write", i, 32'(o_mem_write[i]), 32'(m_ex[i].mem_write));
      check("ex_reg_write", i, 32'(o_reg_write[i]), 32'(m_ex[i].reg_write));
      check("ex_alu_op", i, 32'(o_alu_op[i]), 32'(m_ex[i].alu_op));
`ifdef BUBBLE_COUNTER_EN
      check("bubble_count", i, o_bc[i], m_bc[i]);
`endif
    end
  endtask

  task automatic rand_data();
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_immediate = 1'($urandom); id_pc_operation = 1'($urandom);
    id_mem_write = 1'($urandom); id_alu_op = 4'($urandom);
  endtask

  function automatic vec_t mk(input bit r, s, f, v, input logic [4:0] rd, rs1, rs2,
                              input bit u1, u2, mr, input logic [2:0] eh, ev,
                              input logic [4:0] r0, r1, r2);
    vec_t t;
    t = '{rst: r, stall: s, flush: f, valid: v, rd: rd, rs1: rs1, rs2: rs2, u1: u1,
          u2: u2, mr: mr, eh: eh, ev: ev, r0: r0, r1: r1, r2: r2};
    return t;
  endfunction

  function automatic logic [4:0] pick_reg();
    logic [4:0] regs [4];
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd6;
    return regs[$urandom_range(0, 3)];
  endfunction

  vec_t vt [$];

  initial begin
    logic [4:0] exp_rd;
    for (int i = 0; i < NI; i++) begin
      m_ex[i] = zero_ex(); m_rem[i] = 0; m_bc[i] = 32'd0;
    end
    rst = 1'b1; stall_in = 1'b0; flush_in = 1'b0; id_valid = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_mem_read = 1'b0; id_reg_write = 1'b0;
    rand_data();

    // rst stall flush valid rd rs1 rs2 u1 u2 mr | hold(N3N2N1) ex_valid rd(N1,N2,N3)
    vt.push_back(mk(1,0,0, 1, 5, 2, 0, 1,0,1, 3'b000, 3'b000, 0, 0, 0));
    vt.push_back(mk(1,0,0, 1, 5, 2, 0, 1,0,1, 3'b000, 3'b000, 0, 0, 0));
    vt.push_back(mk(0,0,0, 1, 5, 2, 0, 1,0,1, 3'b000, 3'b111, 5, 5, 5)); // lw x5
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b111, 3'b000, 0, 0, 0)); // add x6,x5,x7
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b110, 3'b001, 6, 0, 0));
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b100, 3'b011, 6, 6, 0));
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b000, 3'b111, 6, 6, 6));
    vt.push_back(mk(0,0,0, 1, 0, 2, 0, 1,0,1, 3'b000, 3'b111, 0, 0, 0)); // lw x0
    vt.push_back(mk(0,0,0, 1, 8, 0, 0, 1,1,0, 3'b000, 3'b111, 8, 8, 8)); // uses x0
    vt.push_back(mk(0,0,0, 1, 5, 2, 0, 1,0,1, 3'b000, 3'b111, 5, 5, 5)); // lw x5
    vt.push_back(mk(0,0,0, 1, 9, 1, 5, 1,0,0, 3'b000, 3'b111, 9, 9, 9)); // rs2=5 unused
    vt.push_back(mk(0,0,0, 1, 5, 1, 0, 1,0,0, 3'b000, 3'b111, 5, 5, 5)); // addi x5
    vt.push_back(mk(0,0,0, 1,10, 5, 0, 1,0,0, 3'b000, 3'b111,10,10,10)); // use x5
    vt.push_back(mk(0,0,0, 1, 5, 2, 0, 1,0,1, 3'b000, 3'b111, 5, 5, 5)); // lw x5
    vt.push_back(mk(0,0,1, 1, 6, 5, 7, 1,1,0, 3'b000, 3'b000, 0, 0, 0)); // flush on haz
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b000, 3'b111, 6, 6, 6));
    vt.push_back(mk(0,0,0, 1, 5, 2, 0, 1,0,1, 3'b000, 3'b111, 5, 5, 5)); // lw x5
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b111, 3'b000, 0, 0, 0));
    vt.push_back(mk(0,0,1, 1, 6, 5, 7, 1,1,0, 3'b000, 3'b000, 0, 0, 0)); // flush in BUBBLE
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b000, 3'b111, 6, 6, 6));
    vt.push_back(mk(0,0,0, 1, 5, 2, 0, 1,0,1, 3'b000, 3'b111, 5, 5, 5)); // lw x5
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b111, 3'b000, 0, 0, 0));
    vt.push_back(mk(0,1,0, 1, 6, 5, 7, 1,1,0, 3'b111, 3'b000, 0, 0, 0)); // stall mid-bubble
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b110, 3'b001, 6, 0, 0));
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b100, 3'b011, 6, 6, 0));
    vt.push_back(mk(0,0,0, 1, 6, 5, 7, 1,1,0, 3'b000, 3'b111, 6, 6, 6));
    vt.push_back(mk(0,1,0, 1,11, 1, 0, 1,0,0, 3'b111, 3'b111, 6, 6, 6)); // plain stall
    vt.push_back(mk(0,0,0, 1,11, 1, 0, 1,0,0, 3'b000, 3'b111,11,11,11));
    vt.push_back(mk(0,0,0, 0,12, 1, 0, 1,0,0, 3'b000, 3'b000,12,12,12)); // invalid slot

    foreach (vt[k]) begin
      rst = vt[k].rst; stall_in = vt[k].stall; flush_in = vt[k].flush;
      id_valid = vt[k].valid; id_rd = vt[k].rd; id_rs1 = vt[k].rs1; id_rs2 = vt[k].rs2;
      id_uses_rs1 = vt[k].u1; id_uses_rs2 = vt[k].u2; id_mem_read = vt[k].mr;
      id_reg_write = 1'b1;
      rand_data();
      pre_edge();
      for (int i = 0; i < NI; i++)
        check($sformatf("tbl%0d_hold", k), i, 32'(o_hold[i]), 32'(vt[k].eh[i]));
      post_edge();
      for (int i = 0; i < NI; i++) begin
        exp_rd = (i == 0) ? vt[k].r0 : (i == 1) ? vt[k].r1 : vt[k].r2;
        check($sformatf("tbl%0d_ex_valid", k), i, 32'(o_valid[i]), 32'(vt[k].ev[i]));
        check($sformatf("tbl%0d_ex_rd", k), i, 32'(o_rd[i]), 32'(exp_rd));
      end
    end

    // Random traffic with a small register pool so load-use pairs are frequent.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      stall_in = ($urandom_range(0, 7) == 0);
      flush_in = ($urandom_range(0, 9) == 0);
      id_valid = ($urandom_range(0, 5) != 0);
      id_rs1 = pick_reg(); id_rs2 = pick_reg(); id_rd = pick_reg();
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      id_mem_read = ($urandom_range(0, 2) == 0);
      id_reg_write = 1'($urandom);
      rand_data();
      pre_edge();
      post_edge();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
